// File: rtl/gat_pkg.sv
// Shared GAT types: fetch FSM states, address widths and the packed
// per-node feature vector used by both the BRAM writer and reader.
package gat_pkg;

  localparam int FEAT_W = 32;
  localparam int FEAT_N = 16;
  localparam int NODES  = 2708;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int NEW_FEATURE_ADDR_W = clog2_min1(NODES * FEAT_N);
  localparam int NODE_IDX_W         = clog2_min1(NODES);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD,
    DONE
  } fetch_state_t;

  typedef logic [FEAT_N-1:0][FEAT_W-1:0] feat_vec_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Valid+tag delay line that tracks BRAM reads in flight so each
// returning word can be matched to the element it was issued for.
module bram_rd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_tag,
  output logic         out_vld,
  output logic [W-1:0] out_tag
);

  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      tag_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/feature_fetcher.sv
// Reads node feature vectors back out of the feature BRAM after the
// convolution completes and streams them out over valid/ready.
module feature_fetcher
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_FEATURE_OUT   = 16,
  parameter int NUM_SUBGRAPHS     = 2708,
  parameter int BRAM_RD_LATENCY   = 2,
  localparam int AW = clog2_min1(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
  localparam int NW = clog2_min1(NUM_SUBGRAPHS),
  localparam int KW = clog2_min1(NUM_FEATURE_OUT)
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        gat_ready,
  output logic [AW-1:0]               feat_bram_addrb,
  output logic                        feat_bram_enb,
  input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_doutb,
  output logic [NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] node_feat,
  output logic                        node_feat_vld,
  input  logic                        node_feat_rdy,
  output logic [NW-1:0]               node_idx,
  output logic                        fetch_done
);

  localparam logic [KW-1:0] K_LAST = KW'(NUM_FEATURE_OUT - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_SUBGRAPHS - 1);

  fetch_state_t  state;
  logic [KW-1:0] k;
  logic          tag_vld;
  logic [KW-1:0] tag_k;

  bram_rd_tag_pipe #(
    .DEPTH (BRAM_RD_LATENCY),
    .W     (KW)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (feat_bram_enb),
    .in_tag  (k),
    .out_vld (tag_vld),
    .out_tag (tag_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      k               <= '0;
      feat_bram_addrb <= '0;
      feat_bram_enb   <= 1'b0;
      node_feat       <= '0;
      node_feat_vld   <= 1'b0;
      node_idx        <= '0;
      fetch_done      <= 1'b0;
    end else begin
      // words come back in reverse element order
      if (tag_vld)
        node_feat[K_LAST - tag_k] <= feat_bram_doutb;

      unique case (state)
        IDLE: begin
          if (gat_ready && !fetch_done) begin
            state           <= FETCH;
            feat_bram_enb   <= 1'b1;
            feat_bram_addrb <= '0;
            k               <= '0;
          end
        end
        FETCH: begin
          if (k == K_LAST) begin
            feat_bram_enb <= 1'b0;
            state         <= DRAIN;
          end else begin
            k               <= k + KW'(1);
            feat_bram_addrb <= feat_bram_addrb + AW'(1);
          end
        end
        DRAIN: begin
          if (tag_vld && tag_k == K_LAST) begin
            node_feat_vld <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (node_feat_rdy) begin
            node_feat_vld <= 1'b0;
            if (node_idx == N_LAST) begin
              fetch_done <= 1'b1;
              state      <= DONE;
            end else begin
              // next base follows directly on the last address read
              node_idx        <= node_idx + NW'(1);
              feat_bram_addrb <= feat_bram_addrb + AW'(1);
              feat_bram_enb   <= 1'b1;
              k               <= '0;
              state           <= FETCH;
            end
          end
        end
        DONE: begin
          feat_bram_enb <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_fetcher.sv
// Directed bench for feature_fetcher with a behavioural 2-cycle BRAM
// and a queue of expected node vectors.
module tb_feature_fetcher;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int NS = 3;
  localparam int L  = 2;
  localparam int AW = 4;
  localparam int NW = 2;
  localparam int CW = N * W;

  typedef logic [CW-1:0] cv_t;

  typedef struct packed {
    logic [NW-1:0] idx;
    logic [CW-1:0] feat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 gat_ready = 1'b0;
  logic                 rdy = 1'b0;
  logic [AW-1:0]        addrb;
  logic                 enb;
  logic [W-1:0]         doutb;
  logic [N-1:0][W-1:0]  node_feat;
  logic                 vld;
  logic [NW-1:0]        node_idx;
  logic                 done;

  int vectors = 0;
  int errs    = 0;

  logic [W-1:0] mem [NS*N];
  logic [W-1:0] rd_s1;
  exp_t         sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (enb) rd_s1 <= mem[addrb];
    doutb <= rd_s1;
  end

  feature_fetcher #(
    .NEW_FEATURE_WIDTH (W),
    .NUM_FEATURE_OUT   (N),
    .NUM_SUBGRAPHS     (NS),
    .BRAM_RD_LATENCY   (L)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gat_ready       (gat_ready),
    .feat_bram_addrb (addrb),
    .feat_bram_enb   (enb),
    .feat_bram_doutb (doutb),
    .node_feat       (node_feat),
    .node_feat_vld   (vld),
    .node_feat_rdy   (rdy),
    .node_idx        (node_idx),
    .fetch_done      (done)
  );

  task automatic chk(input string tag, input cv_t obs, input cv_t exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_linear();
    for (int a = 0; a < NS*N; a++) mem[a] = W'(a);
  endtask

  // word[a]=a, element e of node n sits at n*N+(N-1-e)
  task automatic push_linear();
    exp_t e;
    for (int n = 0; n < NS; n++) begin
      e.idx = NW'(n);
      for (int j = 0; j < N; j++)
        e.feat[j*W +: W] = W'(n*N + N - 1 - j);
      sb.push_back(e);
    end
  endtask

  task automatic take(input string tag);
    exp_t e;
    int   t = 0;
    while (vld !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " vld"}, cv_t'(vld), cv_t'(1));
    if (vld === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " feat"}, cv_t'(node_feat), e.feat);
      chk({tag, " idx"}, cv_t'(node_idx), cv_t'(e.idx));
    end
  endtask

  initial begin
    cv_t           snap_feat;
    logic [NW-1:0] snap_idx;
    exp_t          e;
    logic [W-1:0]  v;
    int            t;

    fill_linear();
    repeat (3) @(negedge clk);
    chk("reset outs", cv_t'({enb, vld, done, addrb, node_idx}), cv_t'(0));
    chk("reset feat", cv_t'(node_feat), cv_t'(0));

    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle", cv_t'({enb, vld, done}), cv_t'(0));
    end

    push_linear();
    gat_ready = 1'b1;
    @(negedge clk);
    chk("first enb", cv_t'({enb, addrb}), cv_t'({1'b1, 4'd0}));
    repeat (3) @(negedge clk);
    chk("last enb", cv_t'({enb, addrb}), cv_t'({1'b1, 4'd3}));
    @(negedge clk);
    chk("enb off", cv_t'(enb), cv_t'(0));
    @(negedge clk);
    chk("vld c6", cv_t'(vld), cv_t'(0));
    @(negedge clk);
    chk("vld c7", cv_t'(vld), cv_t'(1));
    snap_feat = cv_t'(node_feat);
    snap_idx  = node_idx;
    take("node0");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp vld/enb", cv_t'({vld, enb}), cv_t'(2'b10));
      chk("bp feat", cv_t'(node_feat), snap_feat);
      chk("bp idx", cv_t'(node_idx), cv_t'(snap_idx));
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("after hs", cv_t'({vld, enb, addrb}), cv_t'({1'b0, 1'b1, 4'd4}));
    take("node1");
    @(negedge clk);
    take("node2");
    @(negedge clk);
    chk("done", cv_t'({done, vld}), cv_t'(2'b10));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("done hold", cv_t'({enb, vld, done}), cv_t'(3'b001));
    end

    rst_n     = 1'b0;
    gat_ready = 1'b0;
    @(negedge clk);
    for (int n = 0; n < NS; n++) begin
      e.idx = NW'(n);
      for (int j = 0; j < N; j++) begin
        v = $urandom;
        mem[n*N + N - 1 - j] = v;
        e.feat[j*W +: W] = v;
      end
      sb.push_back(e);
    end
    rst_n     = 1'b1;
    gat_ready = 1'b1;
    take("lb0");
    @(negedge clk);
    take("lb1");
    @(negedge clk);
    take("lb2");
    @(negedge clk);
    chk("lb done", cv_t'(done), cv_t'(1));

    fill_linear();
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_linear();
    take("mid n0");
    @(negedge clk);
    t = 0;
    while (!(enb === 1'b1 && addrb === 4'd6) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("reach k2", cv_t'({enb, addrb}), cv_t'({1'b1, 4'd6}));
    rst_n = 1'b0;
    #1;
    chk("mid rst outs", cv_t'({enb, vld, done, addrb, node_idx}), cv_t'(0));
    chk("mid rst feat", cv_t'(node_feat), cv_t'(0));
    @(negedge clk);
    chk("mid rst hold", cv_t'({enb, vld, done}), cv_t'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart addr", cv_t'({enb, addrb}), cv_t'({1'b1, 4'd0}));
    sb.delete();
    push_linear();
    take("re n0");
    @(negedge clk);
    take("re n1");
    @(negedge clk);
    take("re n2");
    @(negedge clk);
    chk("re done", cv_t'(done), cv_t'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
